// File: rtl/scp_pkg.sv
// Shared definitions for the single-cycle core: instruction field positions,
// write-back address select encodings and architectural register numbers.
package scp_pkg;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  typedef enum logic [1:0] {
    WSEL_RT   = 2'b00,
    WSEL_RD   = 2'b01,
    WSEL_RA   = 2'b10,
    WSEL_NONE = 2'b11
  } wsel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_waddr_sel.sv
// Write-back address decode: picks rt, rd or the link register from the
// instruction and qualifies the write (no write to r0 or with reserved select).
module reg_waddr_sel
  import scp_pkg::*;
(
  input  logic [31:0] order,
  input  logic [1:0]  wsel,
  input  logic        we,
  output logic [4:0]  waddr,
  output logic        wr_valid
);

  logic w_unused;
  assign w_unused = ^{order[31:RS_LO], order[RD_LO-1:0]};

  always_comb begin
    waddr    = REG_ZERO;
    wr_valid = 1'b0;
    case (wsel)
      WSEL_RT: waddr = order[RT_HI:RT_LO];
      WSEL_RD: waddr = order[RD_HI:RD_LO];
      WSEL_RA: waddr = REG_RA;
      default: waddr = REG_ZERO;
    endcase
    wr_valid = we && (wsel != WSEL_NONE) && (waddr != REG_ZERO);
  end

endmodule

// File: rtl/reg_file32.sv
// 32 x WIDTH architectural register file: two combinational source ports plus a
// debug port, one write per edge, r0 tied to zero, r29 resets to SP_INIT.
module reg_file32
  import scp_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] SP_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      order,
  input  logic             we,
  input  logic [1:0]       wsel,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [15:0]      wr_count
);

  logic [4:0]       w_waddr;
  logic             w_wr_valid;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [WIDTH-1:0] w_regs [0:31];
  logic [15:0]      r_wr_count;

  reg_waddr_sel u_waddr_sel (
    .order    (order),
    .wsel     (wsel),
    .we       (we),
    .waddr    (w_waddr),
    .wr_valid (w_wr_valid)
  );

  // Each register is its own flop bank so r0 can be a constant rather than storage.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (5'(gi) == REG_ZERO) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_store
        localparam logic [WIDTH-1:0] RST_VAL = (5'(gi) == REG_SP) ? SP_INIT : '0;
        logic [WIDTH-1:0] r_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_q <= RST_VAL;
          end else if (w_wr_valid && (w_waddr == 5'(gi))) begin
            r_q <= wdata;
          end
        end
        assign w_regs[gi] = r_q;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_count <= '0;
    end else if (w_wr_valid && (r_wr_count != 16'hFFFF)) begin
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign w_rs     = order[RS_HI:RS_LO];
  assign w_rt     = order[RT_HI:RT_LO];
  assign rdata1   = w_regs[w_rs];
  assign rdata2   = w_regs[w_rt];
  assign dbg_data = w_regs[dbg_addr];
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_file32.sv
// Self-checking bench for reg_file32: expected values are queued when stimulus
// is applied and compared against the DUT outputs when they are sampled.
module tb_reg_file32;

  localparam logic [31:0] SP = 32'h0000_7FFC;

  logic        clk;
  logic        rst;
  logic [31:0] order;
  logic        we;
  logic [1:0]  wsel;
  logic [31:0] wdata;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [15:0] wr_count;

  reg_file32 #(.WIDTH(32), .SP_INIT(SP)) dut (
    .clk      (clk),
    .rst      (rst),
    .order    (order),
    .we       (we),
    .wsel     (wsel),
    .wdata    (wdata),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_regs [0:31];
  int          m_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? SP : 32'h0;
    m_cnt = 0;
  endtask

  task automatic model_write(input logic [31:0] ord, input logic [1:0] ws, input logic [31:0] wd);
    logic [4:0] a;
    case (ws)
      2'b00:   a = ord[20:16];
      2'b01:   a = ord[15:11];
      2'b10:   a = 5'd31;
      default: a = 5'd0;
    endcase
    if (ws != 2'b11 && a != 5'd0) begin
      m_regs[a] = wd;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic sample_dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    push_exp(tag, exp);
    #1;
    pop_check(dbg_data);
  endtask

  task automatic sample_cnt(input string tag, input int exp);
    push_exp(tag, 32'(exp));
    #0;
    pop_check({16'h0, wr_count});
  endtask

  task automatic sweep_model(input string tag);
    for (int i = 0; i < 32; i++) sample_dbg($sformatf("%s_r%0d", tag, i), 5'(i), m_regs[i]);
    sample_cnt({tag, "_cnt"}, m_cnt);
  endtask

  // Drive one write at a negedge, commit it at the next rising edge.
  task automatic do_write(input logic [31:0] ord, input logic [1:0] ws, input logic [31:0] wd);
    @(negedge clk);
    order = ord;
    wsel  = ws;
    wdata = wd;
    we    = 1'b1;
    @(posedge clk);
    model_write(ord, ws, wd);
    #1;
    we = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    order    = 32'h0;
    we       = 1'b0;
    wsel     = 2'b00;
    wdata    = 32'h0;
    dbg_addr = 5'd0;
    model_reset();

    // Asynchronous reset asserted between edges; outputs settle without a clock edge.
    #12;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++)
      sample_dbg($sformatf("rst_r%0d", i), 5'(i), (i == 29) ? SP : 32'h0);
    sample_cnt("rst_cnt", 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic write through rd.
    do_write(32'h0022_1820, 2'b01, 32'hDEAD_BEEF);
    sample_dbg("wr_rd_r3", 5'd3, 32'hDEAD_BEEF);
    sample_cnt("wr_rd_cnt", 1);
    push_exp("wr_rd_rdata1", 32'h0); #0; pop_check(rdata1);
    push_exp("wr_rd_rdata2", 32'h0); #0; pop_check(rdata2);

    // r0 immunity and reserved select.
    do_write(32'h0000_2000, 2'b00, 32'h1234_5678);
    push_exp("r0_rdata2", 32'h0); #0; pop_check(rdata2);
    sample_cnt("r0_cnt", 1);
    sample_dbg("r0_r4", 5'd4, 32'h0);
    do_write(32'h0022_1820, 2'b11, 32'h0000_0055);
    sample_dbg("none_r3", 5'd3, 32'hDEAD_BEEF);
    sample_dbg("none_r2", 5'd2, 32'h0);
    sample_cnt("none_cnt", 1);

    // Link write.
    do_write(32'h0022_1820, 2'b10, 32'h0000_0040);
    sample_dbg("link_r31", 5'd31, 32'h0000_0040);
    sample_cnt("link_cnt", 2);

    // Read-during-write: old value before the edge, new value after.
    do_write(32'h0005_0000, 2'b00, 32'h7);
    @(negedge clk);
    order = 32'h00A5_0000;
    wsel  = 2'b00;
    wdata = 32'h9;
    we    = 1'b1;
    #1;
    push_exp("rdw_pre_rdata1", 32'h7); #0; pop_check(rdata1);
    push_exp("rdw_pre_rdata2", 32'h7); #0; pop_check(rdata2);
    @(posedge clk);
    model_write(32'h00A5_0000, 2'b00, 32'h9);
    #1;
    we = 1'b0;
    push_exp("rdw_post_rdata1", 32'h9); #0; pop_check(rdata1);
    push_exp("rdw_post_rdata2", 32'h9); #0; pop_check(rdata2);
    sample_cnt("rdw_cnt", 4);

    // Random traffic against the model, then a full sweep.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] ord;
      ord = $urandom;
      do_write(ord, 2'($urandom_range(0, 3)), $urandom);
      push_exp($sformatf("rnd%0d_rdata1", n), m_regs[ord[25:21]]); #0; pop_check(rdata1);
      push_exp($sformatf("rnd%0d_rdata2", n), m_regs[ord[20:16]]); #0; pop_check(rdata2);
    end
    sweep_model("rnd");

    // Reset mid-operation with a write pending: the write is lost.
    do_write(32'h001D_0000, 2'b00, 32'h0000_00AA);
    sample_dbg("sp_wr_r29", 5'd29, 32'h0000_00AA);
    @(negedge clk);
    order = 32'h0007_0000;
    wsel  = 2'b00;
    wdata = 32'h0000_0077;
    we    = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    sample_dbg("mid_rst_r29", 5'd29, SP);
    sample_cnt("mid_rst_cnt", 0);
    @(posedge clk);
    #1;
    sample_dbg("mid_rst_r7", 5'd7, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    #1;
    sweep_model("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
